// File: rtl/elastic_pkg.sv
// Shared constants and helpers for the elastic pipeline cells.
`timescale 1ns/1ps
package elastic_pkg;

    localparam int CLK2Q_DLY_DEF = 1;
    localparam int SETUP_DLY_DEF = 0;
    localparam int READY_DLY_DEF = 1;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/data register pair of the elastic pipe with its ready term.
`timescale 1ns/1ps
module elastic_stage
    import elastic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             FLUSH,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             v_r;
    logic [WIDTH-1:0] d_r;

    // An empty stage always accepts, which is what collapses bubbles.
    assign in_ready  = !v_r | out_ready;
    assign out_valid = v_r;
    assign out_data  = d_r;

    // Stage register: flush clears valid only; data loads on valid transfers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            v_r <= 1'b0;
            d_r <= {WIDTH{1'b0}};
        end else if (FLUSH) begin
            v_r <= 1'b0;
        end else if (in_ready) begin
            v_r <= in_valid;
            if (in_valid) begin
                d_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready pipeline register with flush, occupancy count
// and timing arcs for the STA test flow.
`timescale 1ns/1ps
module elastic_pipe
    import elastic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int CLK2Q_DLY = CLK2Q_DLY_DEF,
    parameter int SETUP_DLY = SETUP_DLY_DEF,
    parameter int READY_DLY = READY_DLY_DEF
) (
    input  logic                         CK,
    input  logic                         RN,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             IN_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             OUT_DATA,
    output logic [occ_width(DEPTH)-1:0]  OCC
);

    localparam int OCCW = occ_width(DEPTH);
    localparam logic [OCCW-1:0] OCC_ONE  = OCCW'(1);
    localparam logic [OCCW-1:0] OCC_ZERO = OCCW'(0);

    if (WIDTH < 1 || DEPTH < 1 || CLK2Q_DLY < 0 || SETUP_DLY < 0 || READY_DLY < 0) begin : g_param_check
        $error("elastic_pipe: illegal parameter value");
    end

    logic [DEPTH:0]            valid_s;
    logic [DEPTH:0]            ready_s;
    logic [DEPTH:0][WIDTH-1:0] data_s;
    logic                      in_hs_s;
    logic                      out_hs_s;
    logic [OCCW-1:0]           occ_r;

    assign valid_s[0]     = IN_VALID;
    assign data_s[0]      = IN_DATA;
    assign ready_s[DEPTH] = OUT_READY;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        elastic_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CK        (CK),
            .RN        (RN),
            .FLUSH     (FLUSH),
            .in_valid  (valid_s[i]),
            .in_data   (data_s[i]),
            .in_ready  (ready_s[i]),
            .out_valid (valid_s[i+1]),
            .out_data  (data_s[i+1]),
            .out_ready (ready_s[i+1])
        );
    end

    // Flush blocks input acceptance outright; an output handshake still completes.
    assign IN_READY  = ready_s[0] & !FLUSH;
    assign OUT_VALID = valid_s[DEPTH];
    assign OUT_DATA  = data_s[DEPTH];
    assign in_hs_s   = IN_VALID & IN_READY;
    assign out_hs_s  = OUT_VALID & OUT_READY;
    assign OCC       = occ_r;

    // Occupancy counter tracking the number of valid stages.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            occ_r <= OCC_ZERO;
        end else if (FLUSH) begin
            occ_r <= OCC_ZERO;
        end else begin
            case ({in_hs_s, out_hs_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    specify
        specparam T_CK2Q  = CLK2Q_DLY;
        specparam T_SETUP = SETUP_DLY;
        specparam T_READY = READY_DLY;
        (posedge CK *> (OUT_DATA : IN_DATA)) = T_CK2Q;
        (posedge CK *> (OUT_VALID : IN_VALID)) = T_CK2Q;
        (posedge CK *> (OCC : IN_VALID)) = T_CK2Q;
        $setup(IN_DATA, posedge CK, T_SETUP);
        $setup(IN_VALID, posedge CK, T_SETUP);
        $setup(FLUSH, posedge CK, T_SETUP);
        $setup(OUT_READY, posedge CK, T_SETUP);
        (OUT_READY => IN_READY) = T_READY;
        (FLUSH => IN_READY) = T_READY;
    endspecify

endmodule
